// File: rtl/itrx_aib_phy_tx_redn_seq_if.sv
// Request/status bundle between the AIB config block and the TX redundancy sequencer,
// including the select vectors driven toward the TX IO buffer array.
interface itrx_aib_phy_tx_redn_seq_if #(
    parameter int NUM_IO = 20
);
    logic              cfg_req;
    logic [NUM_IO-1:0] cfg_redn;
    logic [NUM_IO-1:0] cfg_selb;
    logic              cfg_ack;
    logic              cfg_err;
    logic              busy;
    logic [NUM_IO-1:0] redn_engage;
    logic [NUM_IO-1:0] idat_selb;
    logic              tx_quiesce;

    modport master (
        output cfg_req,
        output cfg_redn,
        output cfg_selb,
        input  cfg_ack,
        input  cfg_err,
        input  busy,
        input  redn_engage,
        input  idat_selb,
        input  tx_quiesce
    );

    modport slave (
        input  cfg_req,
        input  cfg_redn,
        input  cfg_selb,
        output cfg_ack,
        output cfg_err,
        output busy,
        output redn_engage,
        output idat_selb,
        output tx_quiesce
    );
endinterface

// File: rtl/itrx_aib_phy_tx_redn_seq.sv
// Glitch-free sequencer for TX AIB redundancy clock-mux and sync/async data selects.
// Optional status outputs (sw_count, last_err) are enabled by ITRX_AIB_PHY_REDN_SEQ_STATUS_EN.
module itrx_aib_phy_tx_redn_seq #(
    parameter int NUM_IO      = 20,
    parameter int QUIESCE_CYC = 4,
    parameter int SETTLE_CYC  = 8
) (
    input  logic clk,
    input  logic rst,
    itrx_aib_phy_tx_redn_seq_if.slave bus
`ifdef ITRX_AIB_PHY_REDN_SEQ_STATUS_EN
    ,
    output logic [7:0] sw_count,
    output logic       last_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        QUIESCE,
        SWITCH,
        SETTLE,
        RESTORE,
        DONE
    } state_t;

    localparam logic [7:0] QUIESCE_LOAD = 8'(QUIESCE_CYC - 1);
    localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nxt;
    logic [NUM_IO-1:0] shadow_redn;
    logic [NUM_IO-1:0] shadow_selb;
    logic              redn_legal;

    logic [NUM_IO-1:0] redn_q;
    logic [NUM_IO-1:0] redn_nxt;
    logic [NUM_IO-1:0] idat_q;
    logic [NUM_IO-1:0] idat_nxt;
    logic              quiesce_q;
    logic              quiesce_nxt;
    logic              ack_q;
    logic              ack_nxt;
    logic              err_q;
    logic              err_nxt;
    logic              busy_q;
    logic              busy_nxt;

    // A legal redn vector is a thermometer filling from the MSB down: any set bit
    // must have its upper neighbour set too.
    always_comb begin
        redn_legal = 1'b1;
        for (int i = 0; i < NUM_IO - 1; i++) begin
            if (shadow_redn[i] && !shadow_redn[i+1]) begin
                redn_legal = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        redn_nxt    = redn_q;
        idat_nxt    = idat_q;
        quiesce_nxt = quiesce_q;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                quiesce_nxt = 1'b0;
                if (bus.cfg_req) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!redn_legal) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (shadow_redn == redn_q) begin
                    state_nxt = RESTORE;
                end else begin
                    idat_nxt    = '1;
                    quiesce_nxt = 1'b1;
                    cnt_nxt     = QUIESCE_LOAD;
                    state_nxt   = QUIESCE;
                end
            end
            QUIESCE: begin
                if (cnt == 8'd0) begin
                    state_nxt = SWITCH;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            SWITCH: begin
                redn_nxt  = shadow_redn;
                cnt_nxt   = SETTLE_LOAD;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    state_nxt = RESTORE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            RESTORE: begin
                idat_nxt    = shadow_selb;
                quiesce_nxt = 1'b0;
                ack_nxt     = 1'b1;
                state_nxt   = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // Reset parks every buffer on the async path with data forced low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            shadow_redn <= '0;
            shadow_selb <= '1;
            redn_q      <= '0;
            idat_q      <= '1;
            quiesce_q   <= 1'b1;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            redn_q    <= redn_nxt;
            idat_q    <= idat_nxt;
            quiesce_q <= quiesce_nxt;
            ack_q     <= ack_nxt;
            err_q     <= err_nxt;
            busy_q    <= busy_nxt;
            if (state == IDLE && bus.cfg_req) begin
                shadow_redn <= bus.cfg_redn;
                shadow_selb <= bus.cfg_selb;
            end
        end
    end

    assign bus.redn_engage = redn_q;
    assign bus.idat_selb   = idat_q;
    assign bus.tx_quiesce  = quiesce_q;
    assign bus.cfg_ack     = ack_q;
    assign bus.cfg_err     = err_q;
    assign bus.busy        = busy_q;

`ifdef ITRX_AIB_PHY_REDN_SEQ_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_count <= 8'd0;
            last_err <= 1'b0;
        end else begin
            if (state == SWITCH && sw_count != 8'hFF) begin
                sw_count <= sw_count + 8'd1;
            end
            if (err_nxt) begin
                last_err <= 1'b1;
            end else if (ack_nxt) begin
                last_err <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/itrx_aib_phy_tx_redn_seq.md
Name: itrx_aib_phy_tx_redn_seq

Overview:
Sequencer that owns the per-buffer redundancy clock-mux select (redn_engage) and the sync/async data select (idat_selb) for an array of NUM_IO TX AIB IO buffers.
- Applies new redundancy/async configurations without runt pulses on the ubumps.
- Sequence: quiesce outputs to async path, switch the clock mux, wait for the mux to settle, then restore data selection.
- Sits between the AIB config/JTAG register block and the TX IO buffer array.

Parameters:
NUM_IO, 20, number of TX IO buffers controlled (width of select vectors)
QUIESCE_CYC, 4, cycles outputs are held on the async path before the clock-mux switch (1..255)
SETTLE_CYC, 8, cycles after the clock-mux switch before data selection is restored (1..255)

Ports:
clk  input  1  controller clock (config-domain clock, free-running)
rst  input  1  asynchronous active-high reset
cfg_req  input  1  request to apply new configuration; held high until cfg_ack or cfg_err
cfg_redn  input  NUM_IO  requested redn_engage vector
cfg_selb  input  NUM_IO  requested idat_selb vector (1 = async data)
cfg_ack  output  1  one-cycle pulse: configuration applied
cfg_err  output  1  one-cycle pulse: request rejected (illegal cfg_redn)
busy  output  1  high while a sequence is in progress (states other than IDLE)
redn_engage  output  NUM_IO  per-buffer redundancy clock-mux select
idat_selb  output  NUM_IO  per-buffer sync/async data-mux select
tx_quiesce  output  1  high while async_data into the buffers must be forced low

Behaviour:
- Reset, asynchronous on rst:
  - redn_engage = 0, idat_selb = all 1s (async, safe), tx_quiesce = 1.
  - cfg_ack = 0, cfg_err = 0, busy = 0; state = IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Legal cfg_redn is a thermometer code: all zeros, or bits k..NUM_IO-1 set and bits 0..k-1 clear, for some k. Any other value is illegal.
- FSM states: IDLE, CHECK, QUIESCE, SWITCH, SETTLE, RESTORE, DONE.
- IDLE:
  - tx_quiesce deasserts one cycle after leaving reset.
  - On cfg_req=1, capture cfg_redn and cfg_selb into shadow registers and go to CHECK.
- CHECK (1 cycle):
  - Illegal shadow redn: pulse cfg_err, return to IDLE. No output changes.
  - Shadow redn equals current redn_engage: skip directly to RESTORE.
  - Otherwise go to QUIESCE.
- QUIESCE:
  - idat_selb = all 1s and tx_quiesce = 1.
  - Hold QUIESCE_CYC cycles using an 8-bit down-counter, then go to SWITCH.
- SWITCH (1 cycle): redn_engage <= shadow redn. Go to SETTLE.
- SETTLE: hold SETTLE_CYC cycles (counter reloaded), then go to RESTORE.
- RESTORE (1 cycle): idat_selb <= shadow selb, tx_quiesce <= 0. Go to DONE.
- DONE (1 cycle): pulse cfg_ack, return to IDLE.
- A new request is sampled only in IDLE. cfg_req must drop for at least one cycle after cfg_ack or cfg_err before the next request.
  - If cfg_req is still high in IDLE the cycle after ack/err, it is treated as a new request (bench checks requester compliance).
- Request latency: cfg_req rise to cfg_ack = QUIESCE_CYC + SETTLE_CYC + 4 cycles on the full path, 3 cycles on the skip path.
- Input changes after capture are ignored until the sequence ends.
- Reset mid-sequence: immediate return to the reset values above. No ack or err is issued.

Optional Feature:
Macro: ITRX_AIB_PHY_REDN_SEQ_STATUS_EN.
- Defined, adds outputs:
  - sw_count (8 bits): counts SWITCH-state entries, saturates at 255, cleared by rst.
  - last_err (1 bit): set on cfg_err, cleared on cfg_ack.
- Undefined: those ports and their logic are absent. Other behaviour is identical.

Test Plan:
- Reset release (NUM_IO=20) -> redn_engage=0x00000, idat_selb=0xFFFFF, tx_quiesce=1 in reset and 0 one cycle later, busy=0.
- cfg_redn=0xFFF00, cfg_selb=0x00000 -> tx_quiesce=1 and idat_selb=0xFFFFF for 4 cycles; then redn_engage=0xFFF00; 8 cycles later idat_selb=0x00000; cfg_ack exactly 16 cycles after cfg_req rise.
- cfg_redn=0x00F00 (bits above 11 clear, non-thermometer) -> cfg_err pulse on cycle 2, no ack, redn_engage/idat_selb unchanged, busy back to 0.
- Request with cfg_redn equal to current redn_engage, cfg_selb=0x0000F -> no quiesce, idat_selb=0x0000F, cfg_ack 3 cycles after cfg_req.
- Assert rst during SETTLE -> outputs return immediately to reset values, no cfg_ack; a subsequent legal request completes normally.
- With ITRX_AIB_PHY_REDN_SEQ_STATUS_EN: 3 switching requests plus 1 illegal -> sw_count=3; last_err=1 after the illegal request, 0 after the next ack.
